pixel_serializer: RTL and testbench

Upstream feeder for the WS2812 single-bit line writer (writepixel). Accepts 24-bit GRB pixel words from the frame source over a valid/ready handshake and presents them MSB-first, one bit per transfer, on the bit writer's value/valid/ready interface. Inserts the WS2812 latch/reset low gap after the last pixel of a frame. Includes a one-entry holding register so consecutive pixels stream with no bit-level gap.

---
 rtl/pixel_serializer.sv | 171 +++++++++++++++++
 tb/tb_pixel_serializer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_serializer.sv
// Pixel-to-bit serializer feeding the WS2812 line writer: one-entry holding register,
// MSB-first shift-out with gapless pixel chaining, and a latch gap after the last pixel.
module pixel_serializer #(
    parameter int unsigned BITS_PER_PIXEL = 24,
    parameter int unsigned LATCH_CYCLES   = 1200
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic [BITS_PER_PIXEL-1:0] pixel_data,
    input  logic                      pixel_last,
    input  logic                      pixel_valid,
    output logic                      pixel_ready,
    output logic                      bit_value,
    output logic                      bit_valid,
    input  logic                      bit_ready,
    output logic                      busy,
    output logic                      frame_done,
    output logic                      underrun
);

    localparam int unsigned CNT_W = (BITS_PER_PIXEL > 1) ? $clog2(BITS_PER_PIXEL) : 1;
    localparam int unsigned LAT_W = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BITS_PER_PIXEL - 1);
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(LATCH_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StLatch
    } state_e;

    state_e                    r_state, w_state_d;
    logic                      r_hold_full, w_hold_full_d;
    logic [BITS_PER_PIXEL-1:0] r_hold_data, w_hold_data_d;
    logic                      r_hold_last, w_hold_last_d;
    logic [BITS_PER_PIXEL-1:0] r_shreg, w_shreg_d;
    logic                      r_cur_last, w_cur_last_d;
    logic [CNT_W-1:0]          r_bit_cnt, w_bit_cnt_d;
    logic [LAT_W-1:0]          r_latch_cnt, w_latch_cnt_d;
    logic                      r_bit_valid, w_bit_valid_d;
    logic                      r_bit_value, w_bit_value_d;
    logic                      r_frame_done, w_frame_done_d;
    logic                      r_underrun, w_underrun_d;

    logic                      w_accept;
    logic                      w_xfer;
    logic                      w_load;
    logic [BITS_PER_PIXEL-1:0] w_shifted;

    assign w_accept  = pixel_valid & ~r_hold_full;
    assign w_xfer    = r_bit_valid & bit_ready;
    assign w_shifted = r_shreg << 1;

    always_comb begin
        w_state_d      = r_state;
        w_hold_full_d  = r_hold_full;
        w_hold_data_d  = r_hold_data;
        w_hold_last_d  = r_hold_last;
        w_shreg_d      = r_shreg;
        w_cur_last_d   = r_cur_last;
        w_bit_cnt_d    = r_bit_cnt;
        w_latch_cnt_d  = r_latch_cnt;
        w_bit_valid_d  = r_bit_valid;
        w_bit_value_d  = r_bit_value;
        w_frame_done_d = 1'b0;
        w_underrun_d   = 1'b0;
        w_load         = 1'b0;

        if (w_accept) begin
            w_hold_full_d = 1'b1;
            w_hold_data_d = pixel_data;
            w_hold_last_d = pixel_last;
        end

        unique case (r_state)
            StIdle: begin
                w_bit_valid_d = 1'b0;
                w_bit_value_d = 1'b0;
                if (r_hold_full) begin
                    w_load    = 1'b1;
                    w_state_d = StShift;
                end
            end
            StShift: begin
                if (w_xfer) begin
                    if (r_bit_cnt != LAST_BIT) begin
                        w_shreg_d     = w_shifted;
                        w_bit_cnt_d   = r_bit_cnt + 1'b1;
                        w_bit_value_d = w_shifted[BITS_PER_PIXEL-1];
                    end else if (r_cur_last) begin
                        w_state_d     = StLatch;
                        w_latch_cnt_d = LAT_INIT;
                        w_bit_valid_d = 1'b0;
                        w_bit_value_d = 1'b0;
                    end else if (r_hold_full) begin
                        // Chain straight into the held pixel so the line sees no gap cycle.
                        w_load = 1'b1;
                    end else begin
                        w_underrun_d  = 1'b1;
                        w_state_d     = StIdle;
                        w_bit_valid_d = 1'b0;
                        w_bit_value_d = 1'b0;
                    end
                end
            end
            StLatch: begin
                w_bit_valid_d = 1'b0;
                w_bit_value_d = 1'b0;
                if (r_latch_cnt == '0) begin
                    w_frame_done_d = 1'b1;
                    w_state_d      = StIdle;
                end else begin
                    w_latch_cnt_d = r_latch_cnt - 1'b1;
                end
            end
            default: begin
                w_state_d     = StIdle;
                w_bit_valid_d = 1'b0;
                w_bit_value_d = 1'b0;
            end
        endcase

        // A load only happens while the hold is full, so it never collides with an accept.
        if (w_load) begin
            w_shreg_d     = r_hold_data;
            w_cur_last_d  = r_hold_last;
            w_hold_full_d = 1'b0;
            w_bit_cnt_d   = '0;
            w_bit_valid_d = 1'b1;
            w_bit_value_d = r_hold_data[BITS_PER_PIXEL-1];
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state      <= StIdle;
            r_hold_full  <= 1'b0;
            r_hold_data  <= '0;
            r_hold_last  <= 1'b0;
            r_shreg      <= '0;
            r_cur_last   <= 1'b0;
            r_bit_cnt    <= '0;
            r_latch_cnt  <= '0;
            r_bit_valid  <= 1'b0;
            r_bit_value  <= 1'b0;
            r_frame_done <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_hold_full  <= w_hold_full_d;
            r_hold_data  <= w_hold_data_d;
            r_hold_last  <= w_hold_last_d;
            r_shreg      <= w_shreg_d;
            r_cur_last   <= w_cur_last_d;
            r_bit_cnt    <= w_bit_cnt_d;
            r_latch_cnt  <= w_latch_cnt_d;
            r_bit_valid  <= w_bit_valid_d;
            r_bit_value  <= w_bit_value_d;
            r_frame_done <= w_frame_done_d;
            r_underrun   <= w_underrun_d;
        end
    end

    assign pixel_ready = ~r_hold_full;
    assign bit_valid   = r_bit_valid;
    assign bit_value   = r_bit_value;
    assign busy        = (r_state != StIdle);
    assign frame_done  = r_frame_done;
    assign underrun    = r_underrun;

endmodule

// File: tb/tb_pixel_serializer.sv
// Directed bench for pixel_serializer: reset, single pixel, streaming, backpressure,
// underrun and mid-frame reset, with expectations computed by hand.
`timescale 1ns/1ps
module tb_pixel_serializer;

    localparam int LAT = 1200;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [23:0] pixel_data = '0;
    logic        pixel_last = 1'b0;
    logic        pixel_valid = 1'b0;
    logic        pixel_ready;
    logic        bit_value;
    logic        bit_valid;
    logic        bit_ready = 1'b0;
    logic        busy;
    logic        frame_done;
    logic        underrun;

    pixel_serializer dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .pixel_data  (pixel_data),
        .pixel_last  (pixel_last),
        .pixel_valid (pixel_valid),
        .pixel_ready (pixel_ready),
        .bit_value   (bit_value),
        .bit_valid   (bit_valid),
        .bit_ready   (bit_ready),
        .busy        (busy),
        .frame_done  (frame_done),
        .underrun    (underrun)
    );

    initial forever #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    logic [24:0] pix_q[$];   // {last, data}
    logic [71:0] acc;
    int n_xfer, n_valid, n_done, n_under, n_pops, n_ready_low;
    int cyc, t_first, t_last, t_done, t_acc;
    logic bp_mode = 1'b0;
    int   bp_phase;
    logic prev_valid, prev_ready, prev_value;

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        acc = '0; n_xfer = 0; n_valid = 0; n_done = 0; n_under = 0; n_pops = 0;
        n_ready_low = 0; t_first = 0; t_last = 0; t_done = 0; t_acc = 0;
        prev_valid = 1'b0; prev_ready = 1'b1; prev_value = 1'b0; bp_phase = 0;
    endtask

    // One cycle: sample outputs at negedge, then drive inputs for the coming posedge.
    task automatic tick();
        @(negedge CLK);
        cyc++;
        if (bp_mode) begin
            bit_ready = (bp_phase == 0);
            bp_phase  = (bp_phase == 2) ? 0 : bp_phase + 1;
        end
        if (bp_mode && prev_valid && !prev_ready && bit_valid)
            check("stall_value", bit_value, prev_value);
        if (pix_q.size() > 0) begin
            pixel_valid = 1'b1;
            pixel_data  = pix_q[0][23:0];
            pixel_last  = pix_q[0][24];
            if (pixel_ready) begin
                if (n_pops == 0) t_acc = cyc;
                n_pops++;
                void'(pix_q.pop_front());
            end else begin
                n_ready_low++;
            end
        end else begin
            pixel_valid = 1'b0;
        end
        if (bit_valid && bit_ready) begin
            if (n_xfer == 0) t_first = cyc;
            t_last = cyc;
            n_xfer++;
            acc = {acc[70:0], bit_value};
        end
        if (bit_valid) n_valid++;
        if (frame_done) begin
            if (n_done == 0) t_done = cyc;
            n_done++;
        end
        if (underrun) n_under++;
        prev_valid = bit_valid;
        prev_ready = bit_ready;
        prev_value = bit_value;
    endtask

    task automatic run_until_done(input int bound);
        for (int i = 0; i < bound && n_done == 0; i++) tick();
        for (int i = 0; i < 3; i++) tick();
    endtask

    initial begin
        cyc = 0;
        clr();

        // Reset held with random inputs
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            pixel_valid = 1'($urandom);
            pixel_last  = 1'($urandom);
            pixel_data  = 24'($urandom);
            bit_ready   = 1'($urandom);
            #1;
            check("rst_pixel_ready", pixel_ready, 1'b1);
            check("rst_bit_valid", bit_valid, 1'b0);
        end
        check("rst_busy", busy, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_underrun", underrun, 1'b0);
        check("rst_bit_value", bit_value, 1'b0);
        @(negedge CLK);
        pixel_valid = 1'b0;
        bit_ready   = 1'b1;
        RST_N       = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("idle_no_valid", n_valid, 0);

        // Single pixel with latch gap
        clr();
        pix_q.push_back({1'b1, 24'hA50FC3});
        run_until_done(2000);
        check("single_bits", acc[23:0], 24'hA50FC3);
        check("single_xfers", n_xfer, 24);
        check("single_latency", t_first - t_acc, 2);
        check("single_gap", t_done - t_last, LAT + 1);
        check("single_valid_cycles", n_valid, 24);
        check("single_done", n_done, 1);
        check("single_underrun", n_under, 0);
        check("single_busy_after", busy, 1'b0);

        // Back-to-back stream of three pixels
        clr();
        pix_q.push_back({1'b0, 24'hFF0000});
        pix_q.push_back({1'b0, 24'h00FF00});
        pix_q.push_back({1'b1, 24'h0000FF});
        run_until_done(3000);
        check("stream_bits", acc, 72'hFF0000_00FF00_0000FF);
        check("stream_xfers", n_xfer, 72);
        check("stream_no_gap", t_last - t_first, 71);
        check("stream_valid_cycles", n_valid, 72);
        check("stream_ready_low", (n_ready_low > 0), 1'b1);
        check("stream_done", n_done, 1);
        check("stream_underrun", n_under, 0);

        // Backpressure: bit_ready high one cycle in three
        clr();
        bp_mode = 1'b1;
        pix_q.push_back({1'b1, 24'h800001});
        run_until_done(3000);
        bp_mode   = 1'b0;
        bit_ready = 1'b1;
        check("bp_xfers", n_xfer, 24);
        check("bp_bits", acc[23:0], 24'h800001);
        check("bp_first_bit", acc[23], 1'b1);
        check("bp_last_bit", acc[0], 1'b1);
        check("bp_done", n_done, 1);

        // Underrun on a non-last pixel without successor
        clr();
        pix_q.push_back({1'b0, 24'h123456});
        for (int i = 0; i < 100 && n_under == 0; i++) tick();
        for (int i = 0; i < 5; i++) tick();
        check("ur_pulses", n_under, 1);
        check("ur_xfers", n_xfer, 24);
        check("ur_bits", acc[23:0], 24'h123456);
        check("ur_busy", busy, 1'b0);
        check("ur_done", n_done, 0);
        clr();
        pix_q.push_back({1'b1, 24'h00AA55});
        run_until_done(2000);
        check("ur_next_bits", acc[23:0], 24'h00AA55);
        check("ur_next_done", n_done, 1);
        check("ur_next_underrun", n_under, 0);

        // Reset in the middle of a pixel while the next one is held
        clr();
        pix_q.push_back({1'b0, 24'hFFFFFF});
        pix_q.push_back({1'b1, 24'hFFFFFF});
        for (int i = 0; i < 100 && n_xfer < 10; i++) tick();
        check("mid_reached_bit10", n_xfer, 10);
        check("mid_hold_full", pixel_ready, 1'b0);
        pix_q.delete();
        pixel_valid = 1'b0;
        RST_N = 1'b0;
        #1;
        check("mid_rst_bit_valid", bit_valid, 1'b0);
        check("mid_rst_bit_value", bit_value, 1'b0);
        check("mid_rst_pixel_ready", pixel_ready, 1'b1);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_frame_done", frame_done, 1'b0);
        check("mid_rst_underrun", underrun, 1'b0);
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        clr();
        for (int i = 0; i < 60; i++) tick();
        check("mid_no_emit", n_valid, 0);
        check("mid_no_busy", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
